tik_sched: RTL and testbench

Timestep scheduler for a neuromorphic node: generates the `tik` pulse consumed by the node's work controller, paces timesteps to a programmable minimum period, and withholds the next `tik` until both the work controller and the spike-output path report idle. Counts completed timesteps, supports a fixed step count or free-running operation with stop, and flags period overruns. Sits between the node configurator and the work controller.

---
 rtl/tik_sched.sv | 162 ++++++++++++++++
 tb/tb_tik_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tik_sched.sv
// tik_sched: timestep scheduler that paces the tik pulse to a minimum period and waits for downstream idle.
// Optional WAIT watchdog (parameter WDT_W, output wdt_timeout) is enabled by defining TIK_SCHED_WDT_EN.
module tik_sched #(
  parameter int TW     = 16,
  parameter int PW     = 16,
  parameter int TIK_HI = 4
`ifdef TIK_SCHED_WDT_EN
  , parameter int WDT_W = 20
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run_start,
  input  logic          run_stop,
  input  logic [TW-1:0] step_num,
  input  logic [PW-1:0] period,
  input  logic          work_config_busy,
  input  logic          spk_route_busy,
  output logic          tik,
  output logic          sched_busy,
  output logic [TW-1:0] step_cnt,
  output logic          run_done,
  output logic          overrun,
  output logic [1:0]    state_dbg
`ifdef TIK_SCHED_WDT_EN
  , output logic        wdt_timeout
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TIKH   = 2'd1,
    SETTLE = 2'd2,
    WAIT   = 2'd3
  } state_t;

  localparam int CW = $clog2(TIK_HI + 4);
  localparam logic [CW-1:0] HI_LAST  = CW'(TIK_HI - 1);
  localparam logic [CW-1:0] SET_LAST = CW'(3);

  state_t        state, state_nx;
  logic [CW-1:0] sub_cnt;
  logic [PW-1:0] per_cnt;
  logic [PW-1:0] period_q;
  logic [PW-1:0] thr;
  logic [TW-1:0] step_num_q;
  logic [TW-1:0] step_inc;
  logic          stop_req;
  logic          any_busy;
  logic          per_ok;
  logic          wait_ok;
  logic          end_run;
  logic          wdt_fire;
  logic          start_ok;
  logic          tik_nx, busy_nx, done_nx;

  // A programmed period of 0 behaves like 1: the threshold bottoms out at 0.
  assign thr      = (period_q == '0) ? '0 : period_q - PW'(1);
  assign per_ok   = (per_cnt >= thr);
  assign any_busy = work_config_busy | spk_route_busy;
  assign wait_ok  = per_ok & ~any_busy;
  assign step_inc = step_cnt + TW'(1);
  assign end_run  = stop_req | run_stop | ((step_num_q != '0) && (step_inc == step_num_q));
  assign start_ok = (state == IDLE) && run_start;
  assign state_dbg = state;

`ifdef TIK_SCHED_WDT_EN
  logic [WDT_W-1:0] wdt_cnt;
  // Fires on the busy WAIT cycle that would take the counter to all-ones.
  assign wdt_fire = (state == WAIT) && any_busy && (wdt_cnt == {{(WDT_W-1){1'b1}}, 1'b0});
`else
  assign wdt_fire = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (run_start) state_nx = TIKH;
      TIKH:    if (sub_cnt == HI_LAST) state_nx = SETTLE;
      SETTLE:  if (sub_cnt == SET_LAST) state_nx = WAIT;
      WAIT: begin
        if (wait_ok)       state_nx = end_run ? IDLE : TIKH;
        else if (wdt_fire) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output logic, registered below so every output comes straight from a flop
  always_comb begin
    tik_nx  = (state_nx == TIKH);
    busy_nx = (state_nx != IDLE);
    done_nx = (state != IDLE) && (state_nx == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tik        <= 1'b0;
      sched_busy <= 1'b0;
      run_done   <= 1'b0;
    end else begin
      tik        <= tik_nx;
      sched_busy <= busy_nx;
      run_done   <= done_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sub_cnt    <= '0;
      per_cnt    <= '0;
      period_q   <= '0;
      step_num_q <= '0;
      step_cnt   <= '0;
      overrun    <= 1'b0;
      stop_req   <= 1'b0;
    end else begin
      sub_cnt <= (state_nx != state) ? '0 : sub_cnt + CW'(1);

      // Period measured from each tik rising edge, saturating on very long waits.
      if ((state_nx == TIKH) && (state != TIKH)) per_cnt <= '0;
      else if (per_cnt != '1)                    per_cnt <= per_cnt + PW'(1);

      if (start_ok) begin
        period_q   <= period;
        step_num_q <= step_num;
      end

      if (start_ok)                     step_cnt <= '0;
      else if ((state == WAIT) && wait_ok) step_cnt <= step_inc;

      if (start_ok)                                        overrun <= 1'b0;
      else if ((state == WAIT) && per_ok && any_busy)      overrun <= 1'b1;

      if (state_nx == IDLE)                      stop_req <= 1'b0;
      else if (run_stop && (state != IDLE))      stop_req <= 1'b1;
    end
  end

`ifdef TIK_SCHED_WDT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdt_cnt     <= '0;
      wdt_timeout <= 1'b0;
    end else begin
      if ((state_nx == WAIT) && (state != WAIT)) wdt_cnt <= '0;
      else if ((state == WAIT) && any_busy)      wdt_cnt <= wdt_cnt + WDT_W'(1);

      if (start_ok)      wdt_timeout <= 1'b0;
      else if (wdt_fire) wdt_timeout <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tik_sched.sv
// Bench for tik_sched: timestamp-based reference model compared every cycle, plus directed
// runs with hand-computed tik rise / run_done cycles relative to the run_start edge.
module tb_tik_sched;

  localparam int TW = 16;
  localparam int PW = 16;
  localparam int TIK_HI = 4;
  localparam int PMAX = (1 << PW) - 1;
`ifdef TIK_SCHED_WDT_EN
  localparam int WDT_W = 6;
  localparam int W = 5 + TW;
`else
  localparam int W = 4 + TW;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run_start = 1'b0;
  logic          run_stop = 1'b0;
  logic [TW-1:0] step_num = '0;
  logic [PW-1:0] period = '0;
  logic          work_config_busy = 1'b0;
  logic          spk_route_busy = 1'b0;
  logic          tik, sched_busy, run_done, overrun;
  logic [TW-1:0] step_cnt;
  logic [1:0]    state_dbg;
`ifdef TIK_SCHED_WDT_EN
  logic          wdt_timeout;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_at = -1;
  int rise_q[$];
  logic [W-1:0] exp_q[$];

  tik_sched #(
    .TW(TW), .PW(PW), .TIK_HI(TIK_HI)
`ifdef TIK_SCHED_WDT_EN
    , .WDT_W(WDT_W)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .run_start(run_start), .run_stop(run_stop),
    .step_num(step_num), .period(period),
    .work_config_busy(work_config_busy), .spk_route_busy(spk_route_busy),
    .tik(tik), .sched_busy(sched_busy), .step_cnt(step_cnt),
    .run_done(run_done), .overrun(overrun), .state_dbg(state_dbg)
`ifdef TIK_SCHED_WDT_EN
    , .wdt_timeout(wdt_timeout)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference model: a run is described by the cycle of the latest tik rise; everything else
  // follows from the offset into that timestep.
  logic          m_act = 1'b0;
  int            m_rise = 0;
  int            m_per = 0;
  logic [TW-1:0] m_sn = '0;
  logic [TW-1:0] m_step = '0;
  logic          m_ovr = 1'b0;
  logic          m_stop = 1'b0;
  logic          m_done = 1'b0;
  logic          m_wto = 1'b0;
  int            m_wdt = 0;

  always @(posedge clk) begin
    int d, pc, thr;
    logic any_b, m_tik;
    cyc++;
    m_done = 1'b0;
    any_b = work_config_busy | spk_route_busy;
    if (!rst_n) begin
      m_act = 1'b0; m_step = '0; m_ovr = 1'b0; m_stop = 1'b0; m_wto = 1'b0; m_wdt = 0;
    end else if (!m_act) begin
      if (run_start) begin
        m_act = 1'b1; m_sn = step_num; m_per = int'(period); m_step = '0;
        m_ovr = 1'b0; m_stop = 1'b0; m_wto = 1'b0; m_rise = cyc;
      end
    end else begin
      d   = cyc - 1 - m_rise;
      thr = (m_per == 0) ? 0 : m_per - 1;
      pc  = (d > PMAX) ? PMAX : d;
      if (d >= TIK_HI + 4) begin
        if (d == TIK_HI + 4) m_wdt = 0;
        if (!any_b && pc >= thr) begin
          m_step = m_step + 1'b1;
          if (m_stop || run_stop || (m_sn != 0 && m_step == m_sn)) begin
            m_act = 1'b0; m_done = 1'b1;
          end else begin
            m_rise = cyc;
          end
        end else begin
          if (any_b && pc >= thr) m_ovr = 1'b1;
`ifdef TIK_SCHED_WDT_EN
          if (any_b) begin
            m_wdt++;
            if (m_wdt == (1 << WDT_W) - 1) begin
              m_act = 1'b0; m_done = 1'b1; m_wto = 1'b1;
            end
          end
`endif
        end
      end
      if (m_act && run_stop) m_stop = 1'b1;
      if (!m_act) m_stop = 1'b0;
    end
    m_tik = m_act && ((cyc - m_rise) < TIK_HI);
`ifdef TIK_SCHED_WDT_EN
    exp_q.push_back({m_tik, m_act, m_done, m_ovr, m_step, m_wto});
`else
    exp_q.push_back({m_tik, m_act, m_done, m_ovr, m_step});
`endif
  end

  // Scoreboard: every cycle against the model, also logging tik rises and run_done for directed checks
  logic tik_d = 1'b0;
  always @(negedge clk) begin
    logic [W-1:0] e, a;
`ifdef TIK_SCHED_WDT_EN
    a = {tik, sched_busy, run_done, overrun, step_cnt, wdt_timeout};
`else
    a = {tik, sched_busy, run_done, overrun, step_cnt};
`endif
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("outputs{tik,busy,done,ovr,step}", 64'(a), 64'(e));
    end
    if (tik === 1'b1 && tik_d !== 1'b1) rise_q.push_back(cyc);
    if (run_done === 1'b1) done_at = cyc;
    tik_d = tik;
  end

  // Driver: one run with busy windows and an optional run_stop cycle, all relative to run_start
  task automatic run_case(input int sn, input int per, input int wlo, input int whi,
                          input int slo, input int shi, input int stop_at,
                          input logic stop_with_start, input int budget);
    int rel;
    rise_q.delete();
    done_at = -1;
    @(negedge clk); #1;
    step_num  = TW'(sn);
    period    = PW'(per);
    run_start = 1'b1;
    run_stop  = stop_with_start;
    start_cyc = cyc;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      rel = cyc - start_cyc;
      run_start        = 1'b0;
      work_config_busy = (rel >= wlo) && (rel <= whi);
      spk_route_busy   = (rel >= slo) && (rel <= shi);
      run_stop         = (rel == stop_at);
      if (done_at >= 0) break;
    end
    work_config_busy = 1'b0;
    spk_route_busy   = 1'b0;
    run_stop         = 1'b0;
    if (done_at < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL run_done_timeout: no run_done within %0d cycles (sn=%0d per=%0d)", budget, sn, per);
    end
  endtask

  task automatic check_rise(input string name, input int idx, input int exp_rel);
    if (idx < rise_q.size()) check(name, 64'(rise_q[idx] - start_cyc), 64'(exp_rel));
    else                     check(name, 64'(-1), 64'(exp_rel));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("reset_tik", 64'(tik), 64'd0);
    check("reset_busy", 64'(sched_busy), 64'd0);
    check("reset_step", 64'(step_cnt), 64'd0);
    check("reset_done_ovr", 64'({run_done, overrun}), 64'd0);
    rst_n = 1'b1;

    // period 20, 3 steps
    run_case(3, 20, -1, -1, -1, -1, -1, 1'b0, 200);
    check("t1_nrise", 64'(rise_q.size()), 64'd3);
    check_rise("t1_rise0", 0, 1);
    check_rise("t1_rise1", 1, 21);
    check_rise("t1_rise2", 2, 41);
    check("t1_done", 64'(done_at - start_cyc), 64'd61);
    check("t1_step", 64'(step_cnt), 64'd3);
    check("t1_ovr", 64'(overrun), 64'd0);

    // work controller busy across the period boundary
    run_case(2, 10, 6, 35, -1, -1, -1, 1'b0, 200);
    check_rise("t2_rise1", 1, 37);
    check("t2_done", 64'(done_at - start_cyc), 64'd47);
    check("t2_ovr", 64'(overrun), 64'd1);
    check("t2_step", 64'(step_cnt), 64'd2);

    // free-run stopped during the 5th tik
    run_case(0, 0, -1, -1, -1, -1, 38, 1'b0, 300);
    check("t3_nrise", 64'(rise_q.size()), 64'd5);
    check_rise("t3_rise4", 4, 37);
    check("t3_done", 64'(done_at - start_cyc), 64'd46);
    check("t3_step", 64'(step_cnt), 64'd5);

    // period 0 and 1 both give the minimum spacing
    run_case(4, 0, -1, -1, -1, -1, -1, 1'b0, 200);
    check_rise("t4a_rise1", 1, 10);
    check_rise("t4a_rise3", 3, 28);
    check("t4a_done", 64'(done_at - start_cyc), 64'd37);
    run_case(4, 1, -1, -1, -1, -1, -1, 1'b0, 200);
    check_rise("t4b_rise1", 1, 10);
    check_rise("t4b_rise3", 3, 28);
    check("t4b_step", 64'(step_cnt), 64'd4);

    // run_start with run_stop in IDLE: stop ignored
    run_case(2, 0, -1, -1, -1, -1, -1, 1'b1, 200);
    check("t6_nrise", 64'(rise_q.size()), 64'd2);
    check("t6_done", 64'(done_at - start_cyc), 64'd19);

    // run_stop in the WAIT exit cycle: that step is counted
    run_case(0, 0, -1, -1, -1, -1, 9, 1'b0, 200);
    check("t7_done", 64'(done_at - start_cyc), 64'd10);
    check("t7_step", 64'(step_cnt), 64'd1);

    // spike path busy holds WAIT
    run_case(1, 0, -1, -1, 3, 12, -1, 1'b0, 200);
    check("t8_done", 64'(done_at - start_cyc), 64'd14);
    check("t8_ovr", 64'(overrun), 64'd1);

    // reset while tik is high
    @(negedge clk); #1;
    step_num = TW'(5); period = '0; run_start = 1'b1; start_cyc = cyc;
    @(negedge clk); #1;
    run_start = 1'b0;
    check("t5_tik_before", 64'(tik), 64'd1);
    rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    check("t5_tik", 64'(tik), 64'd0);
    check("t5_busy", 64'(sched_busy), 64'd0);
    check("t5_step", 64'(step_cnt), 64'd0);
    run_case(1, 0, -1, -1, -1, -1, -1, 1'b0, 200);
    check_rise("t5b_rise0", 0, 1);
    check("t5b_done", 64'(done_at - start_cyc), 64'd10);
    check("t5b_step", 64'(step_cnt), 64'd1);

`ifdef TIK_SCHED_WDT_EN
    // spike path stuck busy: watchdog ends the run after 63 busy WAIT cycles
    run_case(1, 0, -1, -1, 5, 1000, -1, 1'b0, 300);
    check("wdt_done", 64'(done_at - start_cyc), 64'd72);
    check("wdt_flag", 64'(wdt_timeout), 64'd1);
    check("wdt_step", 64'(step_cnt), 64'd0);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL global_timeout: bench did not finish (cycle %0d)", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
